fetch_stage: RTL and testbench

Instruction-fetch stage of the 3-stage RV32I pipeline. It sits directly upstream of the decode/controller stage and holds the PC. It fetches instructions over a request/grant/response instruction-memory interface and presents a registered {valid, pc, instr} bundle to decode. It also absorbs downstream stalls with a one-entry skid buffer and applies branch/jump redirects coming back from execute.

---
 rtl/enum_pkg.sv | 13 +
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enum_pkg.sv
// Shared enums and constants for the RV32I pipeline front end.
package enum_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: holds the PC, issues one imem request at a time, presents a
// registered {valid, pc, instr} bundle to decode with a one-entry skid for stalls.
module fetch_stage
    import enum_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         skid_valid_q, skid_valid_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_instr_q, out_instr_d;

    logic req, fire, deliver, consume, to_out;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    // Request is suppressed while the skid holds data, so nothing can be fetched
    // that would have nowhere to land.
    assign req     = (state_q == S_REQ) && !skid_valid_q;
    assign fire    = req && i_imem_gnt;
    assign deliver = (state_q == S_WAIT) && i_imem_rvalid && !i_redirect;
    assign consume = out_valid_q && !i_stall;
    assign to_out  = deliver && (!out_valid_q || (consume && !skid_valid_q));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (fire) state_d = S_WAIT;
            S_WAIT: if (i_imem_rvalid) begin
                state_d = S_REQ;
                pc_d    = pc_q + 32'd4;
            end
            S_DROP: if (i_imem_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        if (consume) begin
            if (skid_valid_q) begin
                out_pc_d     = skid_pc_q;
                out_instr_d  = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (!deliver) begin
                out_valid_d = 1'b0;
            end
        end

        if (to_out) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = i_imem_rdata;
        end else if (deliver) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_instr_d = i_imem_rdata;
        end

        if (i_redirect) begin
            pc_d         = {i_redirect_pc[31:2], 2'b00};
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            out_instr_d  = NOP_INSTR;
            // A response landing in S_WAIT alongside the redirect is the one owed,
            // so nothing remains to drop.
            if (state_q == S_WAIT || state_q == S_DROP) begin
                state_d = i_imem_rvalid ? S_REQ : S_DROP;
            end else if (fire) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            out_valid_q  <= 1'b0;
            out_pc_q     <= RESET_PC;
            out_instr_q  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = pc_q;
    assign o_if_valid  = out_valid_q;
    assign o_if_pc     = out_pc_q;
    assign o_if_instr  = out_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order stream model plus directed cycle checks.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int n_cmp = 0;
    int n_err = 0;
    int rsp_delay = 1;
    int gnt_block = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_imem_req   (req),
        .o_imem_addr  (addr),
        .i_imem_gnt   (gnt),
        .i_imem_rvalid(rvalid),
        .i_imem_rdata (rdata),
        .o_if_valid   (if_valid),
        .o_if_pc      (if_pc),
        .o_if_instr   (if_instr)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], 16'h0093};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: grants a request unless blocked, responds rsp_delay cycles later.
    initial begin : memory
        logic        pend;
        int          pcnt;
        logic [31:0] paddr;
        pend = 1'b0; pcnt = 0; paddr = '0;
        forever begin
            @(negedge clk);
            rvalid = 1'b0;
            rdata  = 32'hDEAD_BEEF;
            gnt    = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (pcnt == 0) begin
                        rvalid = 1'b1;
                        rdata  = mem(paddr);
                        pend   = 1'b0;
                    end else begin
                        pcnt--;
                    end
                end
                if (req && !pend) begin
                    if (gnt_block > 0) begin
                        gnt_block--;
                    end else begin
                        gnt   = 1'b1;
                        pend  = 1'b1;
                        pcnt  = rsp_delay - 1;
                        paddr = addr;
                    end
                end
            end
        end
    end

    // Model: delivered bundles form the in-order stream from the last redirect
    // target; fetch addresses likewise; stalls hold; redirects flush.
    initial begin : compare
        logic [31:0] exp_pc, exp_fetch, p_pc, p_instr, p_addr;
        logic        p_valid, p_req;
        exp_pc = RST_PC; exp_fetch = RST_PC;
        p_pc = '0; p_instr = '0; p_addr = '0; p_valid = 1'b0; p_req = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                check("rst_valid", {31'b0, if_valid}, 32'd0);
                check("rst_instr", if_instr, NOP);
                check("rst_req",   {31'b0, req}, 32'd0);
                check("rst_addr",  addr, RST_PC);
                exp_pc = RST_PC; exp_fetch = RST_PC;
                p_valid = 1'b0; p_req = 1'b0; p_addr = RST_PC;
            end else begin
                if (p_req && gnt) begin
                    check("fetch_addr", p_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (p_req && !gnt && !redirect) begin
                    check("req_hold",  {31'b0, req}, 32'd1);
                    check("addr_hold", addr, p_addr);
                end
                if (redirect) begin
                    check("flush_valid", {31'b0, if_valid}, 32'd0);
                    check("flush_instr", if_instr, NOP);
                    exp_pc    = {redirect_pc[31:2], 2'b00};
                    exp_fetch = {redirect_pc[31:2], 2'b00};
                end else if (p_valid && stall) begin
                    check("stall_valid", {31'b0, if_valid}, 32'd1);
                    check("stall_pc",    if_pc, p_pc);
                    check("stall_instr", if_instr, p_instr);
                end else if (if_valid) begin
                    check("bundle_pc",    if_pc, exp_pc);
                    check("bundle_instr", if_instr, mem(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
                p_valid = if_valid; p_pc = if_pc; p_instr = if_instr;
                p_req = req; p_addr = addr;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
        @(negedge clk);
        stall = s; redirect = r; redirect_pc = rpc;
    endtask

    task automatic do_reset(input int blk);
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(2);
        gnt_block = blk;
        rsp_delay = 1;
        check("rst_nop", if_instr, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int budget;
        budget = 20;
        while (!req && budget > 0) begin
            tick(1);
            budget--;
        end
        if (!req) begin
            n_cmp++; n_err++;
            $display("FAIL %s: no request within 20 cycles, req=%b required 1", name, req);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 100000", $time);
        $fatal(1);
    end

    initial begin : main
        // Reset and zero-wait stream
        do_reset(0);
        tick(1);  // cycle 1
        check("c1_req",  {31'b0, req}, 32'd1);
        check("c1_addr", addr, 32'h0);
        tick(1);  // cycle 2
        check("c2_valid", {31'b0, if_valid}, 32'd0);
        tick(1);  // cycle 3
        check("c3_addr",  addr, 32'h4);
        check("c3_valid", {31'b0, if_valid}, 32'd1);
        check("c3_pc",    if_pc, 32'h0);
        check("c3_instr", if_instr, 32'h0000_0093);
        tick(2);  // cycle 5
        check("c5_addr",  addr, 32'h8);
        check("c5_pc",    if_pc, 32'h4);
        check("c5_instr", if_instr, 32'h0004_0093);

        // Stall: 0x8 lands in the skid, request held off
        drive(1'b1, 1'b0, '0);
        tick(2);  // cycle 7
        check("skid_req_c7", {31'b0, req}, 32'd0);
        tick(1);  // cycle 8
        check("skid_req_c8", {31'b0, req}, 32'd0);
        check("skid_pc_c8",  if_pc, 32'h4);
        drive(1'b0, 1'b0, '0);
        tick(1);  // cycle 9
        check("unskid_pc",    if_pc, 32'h8);
        check("unskid_instr", if_instr, 32'h0008_0093);
        check("resume_addr",  addr, 32'hC);
        tick(2);  // cycle 11
        check("resume_pc", if_pc, 32'hC);

        // Redirect while a slow response is outstanding
        do_reset(0);
        tick(5);  // cycle 5, 0x8 about to be granted
        rsp_delay = 3;
        tick(1);  // cycle 6, S_WAIT
        drive(1'b0, 1'b1, 32'h0000_0100);
        tick(1);  // cycle 7
        rsp_delay = 1;
        check("rdw_valid", {31'b0, if_valid}, 32'd0);
        check("rdw_req7",  {31'b0, req}, 32'd0);
        drive(1'b0, 1'b0, '0);
        tick(1);  // cycle 8, stale response arrives
        check("rdw_req8", {31'b0, req}, 32'd0);
        tick(1);  // cycle 9
        check("rdw_addr",   addr, 32'h100);
        check("rdw_nostale", {31'b0, if_valid}, 32'd0);
        tick(2);  // cycle 11
        check("rdw_pc",    if_pc, 32'h100);
        check("rdw_instr", if_instr, 32'h0100_0093);

        // Redirect with stall, output and skid both full
        do_reset(0);
        tick(5);
        drive(1'b1, 1'b0, '0);
        tick(3);  // cycle 8
        check("rs_req_full", {31'b0, req}, 32'd0);
        drive(1'b1, 1'b1, 32'h0000_0200);
        tick(1);  // cycle 9
        check("rs_valid", {31'b0, if_valid}, 32'd0);
        check("rs_addr",  addr, 32'h200);
        drive(1'b0, 1'b0, '0);
        tick(1);  // cycle 10
        check("rs_skid_gone", {31'b0, if_valid}, 32'd0);
        tick(1);  // cycle 11
        check("rs_pc", if_pc, 32'h200);

        // Delayed grant, no redirect
        do_reset(3);
        for (int c = 1; c <= 4; c++) begin
            tick(1);
            check("dg_req",  {31'b0, req}, 32'd1);
            check("dg_addr", addr, 32'h0);
        end
        tick(2);  // cycle 6
        check("dg_pc", if_pc, 32'h0);

        // Delayed grant with redirect in cycle 2
        do_reset(3);
        tick(2);
        drive(1'b0, 1'b1, 32'h0000_0040);
        tick(1);  // cycle 3
        check("dgr_addr3", addr, 32'h40);
        drive(1'b0, 1'b0, '0);
        tick(1);  // cycle 4
        check("dgr_addr4", addr, 32'h40);
        tick(2);  // cycle 6
        check("dgr_pc", if_pc, 32'h40);

        // Alignment and wrap
        drive(1'b0, 1'b1, 32'h0000_0102);
        tick(1);
        drive(1'b0, 1'b0, '0);
        wait_req("align_wait");
        check("align_addr", addr, 32'h100);
        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        tick(1);
        drive(1'b0, 1'b0, '0);
        wait_req("wrap_wait0");
        check("wrap_addr_top", addr, 32'hFFFF_FFFC);
        tick(1);
        wait_req("wrap_wait1");
        check("wrap_addr_zero", addr, 32'h0);
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
